gb_rd_bank_collect: RTL and testbench

- Downstream neighbour of the global-buffer read-ID generator.
- Consumes the bank ID (`Rd_ID`) and the generator's `done_t`, and issues a one-hot bank read with a per-bank address.
- Captures the 1-cycle-latency SRAM data, muxes it, and streams it out through a small FIFO with valid/ready.
- Produces `read_out_flag` (advance/credit) and `read_SRAM_done` back to the generator.

---
 rtl/gb_rd_bank_collect_pkg.sv | 10 +
 rtl/gb_rd_bank_collect_fifo.sv | 53 +++++
 rtl/gb_rd_bank_collect.sv | 123 ++++++++++++
 tb/tb_gb_rd_bank_collect.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gb_rd_bank_collect_pkg.sv
// Shared constants and types for the global-buffer bank read path.
package gb_pkg;

    localparam int GB_ID_W     = 4;
    localparam int GB_BANK_MAX = 12;
    localparam int GB_ADDR_W   = 9;

    typedef logic [GB_ADDR_W-1:0] gb_addr_t;

endpackage

// File: rtl/gb_rd_bank_collect_fifo.sv
// Small synchronous FIFO with first-word fall-through head and a sync clear.
module gb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gb_rd_bank_collect.sv
// Bank read issue/capture stage behind the read-ID generator, streaming words out via a FIFO.
// Optional GB_RD_BANK_TAG_EN adds out_bank_id carrying each word's source bank.
module gb_rd_bank_collect
    import gb_pkg::*;
#(
    parameter int BANK_MAX   = GB_BANK_MAX,
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           pull_back,
    input  logic                           enable,
    input  logic [GB_ID_W-1:0]             SRAM_num,
    input  logic [GB_ID_W-1:0]             Rd_ID,
    input  logic                           done_t,
    output logic                           read_out_flag,
    output logic                           read_SRAM_done,
    output logic [BANK_MAX-1:0]            sram_rd_en,
    output logic [BANK_MAX*ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [BANK_MAX*DATA_WIDTH-1:0] sram_rd_data,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
`ifdef GB_RD_BANK_TAG_EN
    output logic [GB_ID_W-1:0]             out_bank_id,
`endif
    output logic                           id_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef GB_RD_BANK_TAG_EN
    localparam int FW = DATA_WIDTH + GB_ID_W;
`else
    localparam int FW = DATA_WIDTH;
`endif

    logic [BANK_MAX-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [BANK_MAX-1:0][DATA_WIDTH-1:0] rd_words;
    logic                                inflight;
    logic                                push_d1;
    logic [GB_ID_W-1:0]                  id_d1;
    logic                                id_ok;
    logic                                issue_ok;
    logic                                credit_ok;
    logic                                push;
    logic                                pop;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic [CW-1:0]                       fifo_count;
    logic [FW-1:0]                       fifo_wdata;
    logic [FW-1:0]                       fifo_rdata;

    assign rd_words     = sram_rd_data;
    assign sram_rd_addr = addr_q;

    // An issued read holds a FIFO slot until its word lands, so inflight counts as occupancy.
    assign credit_ok     = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign id_ok         = (Rd_ID < SRAM_num) && (int'(Rd_ID) < BANK_MAX);
    assign read_out_flag = enable & ~done_t & ~pull_back & ~start & credit_ok;
    assign issue_ok      = read_out_flag & id_ok;

    for (genvar b = 0; b < BANK_MAX; b++) begin : g_bank
        assign sram_rd_en[b] = issue_ok && (Rd_ID == GB_ID_W'(b));
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BANK_MAX; b++) begin
            if (rst || start || pull_back)
                addr_q[b] <= '0;
            else if (sram_rd_en[b])
                addr_q[b] <= addr_q[b] + 1'b1;
        end
    end

    // Invalid IDs still consume a credit slot but never produce a push.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            inflight <= 1'b0;
            push_d1  <= 1'b0;
            id_d1    <= '0;
            id_err   <= 1'b0;
        end else begin
            inflight <= read_out_flag;
            push_d1  <= issue_ok;
            if (read_out_flag)          id_d1  <= Rd_ID;
            if (read_out_flag & ~id_ok) id_err <= 1'b1;
        end
    end

    assign push = push_d1 & ~fifo_full;
    assign pop  = out_valid & out_ready;

`ifdef GB_RD_BANK_TAG_EN
    assign fifo_wdata  = {id_d1, rd_words[id_d1]};
    assign out_bank_id = fifo_rdata[FW-1 -: GB_ID_W];
`else
    assign fifo_wdata  = rd_words[id_d1];
`endif

    gb_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid      = ~fifo_empty;
    assign out_data       = fifo_rdata[DATA_WIDTH-1:0];
    assign read_SRAM_done = done_t & ~inflight & (fifo_count == '0) & ~start;

endmodule

// File: tb/tb_gb_rd_bank_collect.sv
// Directed bench for gb_rd_bank_collect; SRAM model returns {bank, addr} one cycle after rd_en.
module tb_gb_rd_bank_collect;

    localparam int BM = 12;
    localparam int DW = 96;
    localparam int AW = 9;

    logic              clk = 1'b0;
    logic              rst, start, pull_back, enable, done_t, out_ready;
    logic [3:0]        SRAM_num, Rd_ID;
    logic              read_out_flag, read_SRAM_done, out_valid, id_err;
    logic [BM-1:0]     sram_rd_en;
    logic [BM*AW-1:0]  sram_rd_addr;
    logic [BM*DW-1:0]  sram_rd_data;
    logic [DW-1:0]     out_data;
    logic [BM-1:0][DW-1:0] mem_q;
`ifdef GB_RD_BANK_TAG_EN
    logic [3:0]        out_bank_id;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gb_rd_bank_collect dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pull_back      (pull_back),
        .enable         (enable),
        .SRAM_num       (SRAM_num),
        .Rd_ID          (Rd_ID),
        .done_t         (done_t),
        .read_out_flag  (read_out_flag),
        .read_SRAM_done (read_SRAM_done),
        .sram_rd_en     (sram_rd_en),
        .sram_rd_addr   (sram_rd_addr),
        .sram_rd_data   (sram_rd_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef GB_RD_BANK_TAG_EN
        .out_bank_id    (out_bank_id),
`endif
        .id_err         (id_err)
    );

    // Each bank returns {bank[3:0], addr[8:0]} in its low bits, one cycle after rd_en.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BM; b++)
            if (sram_rd_en[b])
                mem_q[b] <= DW'({4'(b), sram_rd_addr[b*AW +: AW]});
    end
    assign sram_rd_data = mem_q;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [3:0]  ids1 [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    logic [95:0] exp1 [6] = '{96'h000, 96'h200, 96'h400, 96'h001, 96'h201, 96'h401};
    logic [95:0] exp2 [4] = '{96'h000, 96'h200, 96'h400, 96'h001};

    initial begin
        rst = 1'b1; start = 1'b0; pull_back = 1'b0; enable = 1'b0; done_t = 1'b0;
        out_ready = 1'b0; SRAM_num = 4'd0; Rd_ID = 4'd0;
        for (int b = 0; b < BM; b++) mem_q[b] = '0;

        // Reset state
        step(); step(); #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_flag", read_out_flag, 1'b0);
        chk("rst_done", read_SRAM_done, 1'b0);
        chk("rst_err", id_err, 1'b0);
        chk("rst_en", sram_rd_en, 12'h000);
        chk("rst_addr", sram_rd_addr, '0);

        // Scenario 1: round-robin over three banks, streaming at full rate
        step(); rst = 1'b0; SRAM_num = 4'd3; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            enable = (k < 6);
            Rd_ID  = (k < 6) ? ids1[k] : 4'd0;
            #1;
            chk("s1_flag", read_out_flag, (k < 6));
            if (k < 6) chk("s1_en", sram_rd_en, 12'd1 << ids1[k]);
            if (k == 3) chk("s1_addr_b0", sram_rd_addr[0 +: AW], 9'd1);
            if (k >= 2) begin
                chk("s1_valid", out_valid, 1'b1);
                chk("s1_data", out_data, exp1[k-2]);
`ifdef GB_RD_BANK_TAG_EN
                chk("s1_tag", out_bank_id, ids1[k-2]);
`endif
            end else begin
                chk("s1_valid_lat", out_valid, 1'b0);
            end
        end
        step(); #1;
        chk("s1_drained", out_valid, 1'b0);

        // Scenario 2: back-pressure caps issue at FIFO_DEPTH outstanding words
        step(); start = 1'b1; enable = 1'b0; #1;
        chk("s2_start_flag", read_out_flag, 1'b0);
        step(); start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            enable = 1'b1;
            Rd_ID  = 4'(k % 3);
            #1;
            chk("s2_flag", read_out_flag, (k < 4));
        end
        step(); out_ready = 1'b1; #1;
        chk("s2_head_valid", out_valid, 1'b1);
        chk("s2_head", out_data, exp2[0]);
        step(); #1;
        chk("s2_resume_flag", read_out_flag, 1'b1);
        chk("s2_second", out_data, exp2[1]);
        step(); enable = 1'b0; #1;
        chk("s2_third", out_data, exp2[2]);
        step(); #1;
        chk("s2_fourth", out_data, exp2[3]);
        step(); #1;
        chk("s2_fifth", out_data, 96'h201);
        step(); #1;
        chk("s2_empty", out_valid, 1'b0);

        // Scenario 3: pull_back rewinds bank 1 while a read is in flight
        step(); start = 1'b1; #1;
        step(); start = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(); enable = 1'b1; Rd_ID = 4'd1; #1;
            chk("s3_addr_b1", sram_rd_addr[AW +: AW], 9'(k));
        end
        step(); pull_back = 1'b1; #1;
        chk("s3_pb_flag", read_out_flag, 1'b0);
        chk("s3_pb_en", sram_rd_en, 12'h000);
        chk("s3_pb_data", out_data, 96'h203);
        step(); pull_back = 1'b0; #1;
        chk("s3_rew_flag", read_out_flag, 1'b1);
        chk("s3_rew_addr", sram_rd_addr[AW +: AW], 9'd0);
        chk("s3_rew_en", sram_rd_en, 12'h002);
        chk("s3_inflight_data", out_data, 96'h204);
        chk("s3_inflight_valid", out_valid, 1'b1);
        step(); enable = 1'b0; #1;
        chk("s3_gap", out_valid, 1'b0);
        step(); #1;
        chk("s3_rew_data", out_data, 96'h200);

        // Scenario 4: read_SRAM_done waits for the queue to drain
        step(); start = 1'b1; #1;
        step(); start = 1'b0; out_ready = 1'b0; enable = 1'b1; Rd_ID = 4'd0; #1;
        chk("s4_issue0", read_out_flag, 1'b1);
        step(); Rd_ID = 4'd1; #1;
        step(); enable = 1'b0; done_t = 1'b1; #1;
        chk("s4_done_inflight", read_SRAM_done, 1'b0);
        step(); #1;
        chk("s4_done_queued", read_SRAM_done, 1'b0);
        step(); out_ready = 1'b1; #1;
        chk("s4_done_pop1", read_SRAM_done, 1'b0);
        chk("s4_data0", out_data, 96'h000);
        step(); #1;
        chk("s4_done_pop2", read_SRAM_done, 1'b0);
        chk("s4_data1", out_data, 96'h200);
        step(); #1;
        chk("s4_done_set", read_SRAM_done, 1'b1);
        step(); start = 1'b1; #1;
        chk("s4_done_start", read_SRAM_done, 1'b0);
        step(); start = 1'b0; done_t = 1'b0; #1;
        chk("s4_done_after", read_SRAM_done, 1'b0);

        // Scenario 5: out-of-range bank ID
        step(); SRAM_num = 4'd2; enable = 1'b1; Rd_ID = 4'd3; #1;
        chk("s5_flag", read_out_flag, 1'b1);
        chk("s5_en", sram_rd_en, 12'h000);
        step(); enable = 1'b0; #1;
        chk("s5_err", id_err, 1'b1);
        chk("s5_addr_b3", sram_rd_addr[3*AW +: AW], 9'd0);
        step(); #1;
        chk("s5_no_push", out_valid, 1'b0);
        chk("s5_err_sticky", id_err, 1'b1);
        step(); rst = 1'b1; #1;
        step(); rst = 1'b0; #1;
        chk("s5_err_cleared", id_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
